// File: rtl/truth_table_checker_pkg.sv
// Shared constants and FSM encoding for the truth-table sweep checker.
// Imported by the checker and its bench so both agree on vector count and states.
package truth_table_checker_pkg;
    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/truth_table_checker_settle_counter.sv
// Loadable down-counter timing how long each vector settles before sampling.
// Load has priority over enable; the count stops at zero.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/truth_table_checker.sv
// Drives all 16 input vectors to a combinational DUT in ascending order and
// compares its output against a constant truth table, counting mismatches.
//
// state     | meaning
// ST_IDLE   | waiting for start; results of the last sweep held
// ST_APPLY  | vector on abcd_out, settle counter running
// ST_SAMPLE | f_in compared with EXPECTED[index]
// ST_DONE   | one-cycle done pulse, pass registered
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter logic [NUM_VECTORS-1:0] EXPECTED    = 16'h0000,
    parameter int                     HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             f_in,
    output logic [IDX_W-1:0] abcd_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             first_fail_valid
);
    // APPLY spends HOLD_CYCLES cycles, the last one being the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             cnt_load, cnt_en, cnt_zero;
    logic             sweep_start, sample;
    logic             mismatch;

    settle_counter #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        sweep_start = 1'b0;
        sample      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_APPLY;
                    sweep_start = 1'b1;
                    cnt_load    = 1'b1;
                end
            end
            ST_APPLY: begin
                if (cnt_zero) state_nxt = ST_SAMPLE;
                else          cnt_en    = 1'b1;
            end
            ST_SAMPLE: begin
                sample = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_APPLY;
                    cnt_load  = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mismatch = (f_in != EXPECTED[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            err_count        <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            if (sweep_start) begin
                idx              <= '0;
                err_count        <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
            end else if (sample) begin
                if (mismatch) begin
                    err_count <= err_count + 5'd1;
                    if (!first_fail_valid) begin
                        first_fail_idx   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            end
            // err_count already includes the last vector by the time DONE is reached
            if (state == ST_DONE) pass <= (err_count == 5'd0);
        end
    end

    assign abcd_out = idx;
    assign busy     = (state == ST_APPLY) || (state == ST_SAMPLE);
    assign done     = (state == ST_DONE);
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (AND4 table, OR4 table) driven by
// table-lookup DUT models, with results predicted from popcount/first-difference.
module tb_truth_table_checker;
    import truth_table_checker_pkg::*;

    localparam logic [15:0] EXP_A  = 16'h8000;
    localparam logic [15:0] EXP_B  = 16'hFFFE;
    localparam int          HOLD_A = 2;
    localparam int          HOLD_B = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [2];
    logic        f_in [2];
    logic [3:0]  abcd [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [4:0]  errc [2];
    logic [3:0]  ffi [2];
    logic        ffv [2];
    logic [15:0] tbl [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f_in[0] = tbl[0][abcd[0]];
    assign f_in[1] = tbl[1][abcd[1]];

    truth_table_checker #(.EXPECTED(EXP_A), .HOLD_CYCLES(HOLD_A)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f_in[0]),
        .abcd_out(abcd[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_fail_idx(ffi[0]), .first_fail_valid(ffv[0])
    );

    truth_table_checker #(.EXPECTED(EXP_B), .HOLD_CYCLES(HOLD_B)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f_in[1]),
        .abcd_out(abcd[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_fail_idx(ffi[1]), .first_fail_valid(ffv[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hold_of(input int u);
        return (u == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic logic [15:0] exp_of(input int u);
        return (u == 0) ? EXP_A : EXP_B;
    endfunction

    // Reference: mismatches among vectors [0, upto) and the lowest mismatching vector.
    function automatic int ref_errs(input logic [15:0] t, input logic [15:0] e, input int upto);
        int n = 0;
        for (int i = 0; i < upto; i++) if (t[i] != e[i]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [15:0] t, input logic [15:0] e);
        for (int i = 0; i < NUM_VECTORS; i++) if (t[i] != e[i]) return i;
        return -1;
    endfunction

    task automatic chk_reset_outputs(input int u, input string name);
        chk({name, "_abcd"}, abcd[u], 0);
        chk({name, "_busy"}, busy[u], 0);
        chk({name, "_done"}, done[u], 0);
        chk({name, "_pass"}, pass[u], 0);
        chk({name, "_err"},  errc[u], 0);
        chk({name, "_ffi"},  ffi[u], 0);
        chk({name, "_ffv"},  ffv[u], 0);
    endtask

    // One full sweep on unit u with DUT truth table t; start re-pulsed in cycle
    // 'repulse' (0 = never). Cycle 0 is the cycle in which start is sampled.
    task automatic run_sweep(input int u, input logic [15:0] t, input int repulse, input string name);
        int h, tdone, ne, nf;
        h     = hold_of(u);
        tdone = NUM_VECTORS * (h + 1) + 1;
        ne    = ref_errs(t, exp_of(u), NUM_VECTORS);
        nf    = ref_first(t, exp_of(u));
        tbl[u] = t;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        chk({name, "_clr_err"},  errc[u], 0);
        chk({name, "_clr_ffv"},  ffv[u], 0);
        chk({name, "_clr_pass"}, pass[u], 0);
        for (int c = 1; c <= tdone + 2; c++) begin
            if (c > 1) @(negedge clk);
            start[u] = (c == repulse);
            chk({name, "_busy"}, busy[u], (c < tdone) ? 1 : 0);
            chk({name, "_done"}, done[u], (c == tdone) ? 1 : 0);
            if (c < tdone) chk({name, "_abcd"}, abcd[u], (c - 1) / (h + 1));
            if (c == tdone || c == tdone + 2) begin
                chk({name, "_err"},  errc[u], ne);
                chk({name, "_ffv"},  ffv[u], (nf >= 0) ? 1 : 0);
                if (c == tdone + 2) chk({name, "_pass"}, pass[u], (ne == 0) ? 1 : 0);
                if (nf >= 0) chk({name, "_ffi"}, ffi[u], nf);
            end
        end
        start[u] = 1'b0;
        chk({name, "_abcd_hold"}, abcd[u], NUM_VECTORS - 1);
    endtask

    initial begin
        int u, r, k, tdb;
        logic [15:0] t;
        start[0] = 1'b0; start[1] = 1'b0;
        tbl[0] = '0;     tbl[1] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs(0, "rst_a");
        chk_reset_outputs(1, "rst_b");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 16'h8000, 0, "and4");
        run_sweep(1, 16'h0000, 0, "stuck0");
        run_sweep(0, 16'h8000, 10, "repulse");
        run_sweep(0, 16'h7FFF, 0, "all_wrong");
        tdb = NUM_VECTORS * (HOLD_B + 1) + 1;
        run_sweep(1, 16'hFFFE, tdb, "start_on_done");

        for (int i = 0; i < 4; i++) begin
            u = $urandom_range(0, 1);
            t = 16'($urandom);
            r = $urandom_range(0, 2);
            run_sweep(u, t, (r == 0) ? 0 : (r == 1) ? 10 : NUM_VECTORS * (hold_of(u) + 1) + 1, "rand");
        end

        run_sweep(0, 16'h0000, 0, "b2b_fail");
        run_sweep(0, 16'h8000, 0, "b2b_pass");

        // Asynchronous reset while vector 7 is applied
        tbl[0] = 16'hFFFF;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 0;
        while (abcd[0] != 4'd7 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached7", abcd[0], 7);
        chk("mid_err", errc[0], ref_errs(16'hFFFF, EXP_A, 7));
        chk("mid_ffv", ffv[0], 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs(0, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", done[0], 0);
            chk("post_rst_idle", busy[0], 0);
        end
        run_sweep(0, 16'h8000, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
